// File: rtl/qam_top.sv
// Streaming QAM symbol mapper: splits a 32-bit word MSB-first into k-bit
// symbols and Gray-maps each symbol onto signed {I,Q} amplitudes.
module qam_top #(
    parameter int AMP = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] signal_in,
    input  logic [2:0]  qam,
    output logic [31:0] signal_out,
    output logic        ready,
    output logic        valid,
    output logic        error
);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t      r_state;
    state_t      w_nextState;
    logic [31:0] r_shift;
    logic [2:0]  r_qam;
    logic [3:0]  r_count;
    logic [31:0] r_out;
    logic        r_valid;
    logic        r_error;

    logic [3:0]  w_lastIdx;
    logic        w_atLast;
    logic        w_ready;
    logic        w_qamOk;

    // Bits per symbol for a constellation code; invalid codes never shift.
    function automatic logic [3:0] bitsPerSymbol(input logic [2:0] q);
        case (q)
            3'd0:    return 4'd2;
            3'd1:    return 4'd4;
            3'd2:    return 4'd6;
            3'd3:    return 4'd8;
            default: return 4'd0;
        endcase
    endfunction

    // Index of the final symbol in a word (N-1), so a 4-bit counter suffices.
    function automatic logic [3:0] lastIndex(input logic [2:0] q);
        case (q)
            3'd0:    return 4'd15;
            3'd1:    return 4'd7;
            3'd2:    return 4'd4;
            3'd3:    return 4'd3;
            default: return 4'd0;
        endcase
    endfunction

    // Gray code (zero-extended to 4 bits) to amplitude (2*b-(L-1))*AMP.
    function automatic logic [15:0] level(input logic [3:0] code,
                                          input logic [3:0] lm1);
        logic [3:0] b;
        b = code ^ (code >> 1) ^ (code >> 2) ^ (code >> 3);
        return 16'((2 * int'(b) - int'(lm1)) * AMP);
    endfunction

    // Split the top k bits of sym into I (upper half) and Q (lower half) codes.
    function automatic logic [31:0] mapSymbol(input logic [7:0] sym,
                                              input logic [2:0] q);
        logic [3:0] iCode;
        logic [3:0] qCode;
        logic [3:0] lm1;
        iCode = 4'd0;
        qCode = 4'd0;
        lm1   = 4'd0;
        case (q)
            3'd0: begin
                iCode = {3'b000, sym[7]};
                qCode = {3'b000, sym[6]};
                lm1   = 4'd1;
            end
            3'd1: begin
                iCode = {2'b00, sym[7:6]};
                qCode = {2'b00, sym[5:4]};
                lm1   = 4'd3;
            end
            3'd2: begin
                iCode = {1'b0, sym[7:5]};
                qCode = {1'b0, sym[4:2]};
                lm1   = 4'd7;
            end
            3'd3: begin
                iCode = sym[7:4];
                qCode = sym[3:0];
                lm1   = 4'd15;
            end
            default: begin
                iCode = 4'd0;
                qCode = 4'd0;
                lm1   = 4'd0;
            end
        endcase
        return {level(iCode, lm1), level(qCode, lm1)};
    endfunction

    assign w_lastIdx = lastIndex(r_qam);
    assign w_atLast  = (r_count == w_lastIdx);
    assign w_qamOk   = !qam[2];
    assign w_ready   = !rst && ((r_state == IDLE) || ((r_state == BUSY) && w_atLast));

    // State register; reset always returns to IDLE and drops any burst.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next state: a load with a valid code starts or continues a burst.
    always_comb begin
        w_nextState = r_state;
        if (w_ready) begin
            w_nextState = w_qamOk ? BUSY : IDLE;
        end
    end

    // Datapath: load emits symbol 0 at once, BUSY emits the following symbols.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift <= 32'd0;
            r_qam   <= 3'd0;
            r_count <= 4'd0;
            r_out   <= 32'd0;
            r_valid <= 1'b0;
            r_error <= 1'b0;
        end else if (w_ready) begin
            r_qam   <= qam;
            r_count <= 4'd0;
            if (w_qamOk) begin
                r_error <= 1'b0;
                r_valid <= 1'b1;
                r_out   <= mapSymbol(signal_in[31:24], qam);
                r_shift <= signal_in << bitsPerSymbol(qam);
            end else begin
                r_error <= 1'b1;
                r_valid <= 1'b0;
                r_out   <= 32'd0;
                r_shift <= signal_in;
            end
        end else if (r_state == BUSY) begin
            r_count <= r_count + 4'd1;
            r_valid <= 1'b1;
            r_out   <= mapSymbol(r_shift[31:24], r_qam);
            r_shift <= r_shift << bitsPerSymbol(r_qam);
        end else begin
            r_valid <= 1'b0;
            r_out   <= 32'd0;
        end
    end

    assign signal_out = r_out;
    assign ready      = w_ready;
    assign valid      = r_valid;
    assign error      = r_error;

endmodule

// File: tb/tb_qam_top.sv
// Testbench for qam_top: directed words with hand-computed symbol values
// queued as expectations and checked as the mapper emits them.
module tb_qam_top;

    logic        clk;
    logic        rst;
    logic [31:0] signal_in;
    logic [2:0]  qam;
    logic [31:0] signal_out;
    logic        ready;
    logic        valid;
    logic        error;

    logic [31:0] expQ[$];
    int          compared;
    int          mismatched;

    qam_top #(.AMP(1024)) dut (
        .clk        (clk),
        .rst        (rst),
        .signal_in  (signal_in),
        .qam        (qam),
        .signal_out (signal_out),
        .ready      (ready),
        .valid      (valid),
        .error      (error)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison: counts it and reports any difference.
    task automatic checkOutput(input string name, input logic [31:0] got,
                               input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    // Queue n copies of an expected {I,Q} symbol.
    task automatic pushRepeat(input logic [31:0] value, input int n);
        for (int i = 0; i < n; i++) expQ.push_back(value);
    endtask

    // Wait (bounded) for ready, present a word for one edge, then fall back
    // to an unsupported code so the block idles unless driven again.
    task automatic applyStimulus(input logic [31:0] word, input logic [2:0] q);
        int budget;
        budget = 0;
        while (ready !== 1'b1 && budget < 64) begin
            @(negedge clk);
            budget++;
        end
        checkOutput("loadReady", {31'd0, ready}, 32'd1);
        signal_in = word;
        qam       = q;
        @(posedge clk);
        #1;
        qam = 3'd7;
    endtask

    // Walk through an n-symbol burst: valid every cycle, error clear,
    // ready only while the last symbol is shown. Returns on that cycle.
    task automatic checkBurst(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            checkOutput("burstValid", {31'd0, valid}, 32'd1);
            checkOutput("burstError", {31'd0, error}, 32'd0);
            checkOutput("burstReady", {31'd0, ready}, {31'd0, (i == n - 1)});
        end
    endtask

    // Monitor: every valid symbol must match the next queued expectation.
    always @(negedge clk) begin
        if (valid === 1'b1) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpectedSymbol", signal_out, 32'hxxxxxxxx);
            end else begin
                checkOutput("symbol", signal_out, expQ.pop_front());
            end
        end
    end

    // Hard stop in case something stalls forever.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired compared=%0d", compared);
        $fatal(1, "[TB] watchdog");
    end

    // Directed sequence covering reset, all constellations, back-to-back
    // loads, unsupported codes and a mid-burst reset.
    initial begin
        compared   = 0;
        mismatched = 0;
        rst        = 1'b1;
        signal_in  = 32'hFFFF_FFFF;
        qam        = 3'd0;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("rstValid", {31'd0, valid}, 32'd0);
        checkOutput("rstOut", signal_out, 32'd0);
        checkOutput("rstError", {31'd0, error}, 32'd0);
        checkOutput("rstReady", {31'd0, ready}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("readyAfterRst", {31'd0, ready}, 32'd1);

        $display("[TB] 4-QAM all ones");
        pushRepeat(32'h0400_0400, 16);
        applyStimulus(32'hFFFF_FFFF, 3'd0);
        checkBurst(16);

        $display("[TB] 4-QAM all zeros, back-to-back");
        pushRepeat(32'hFC00_FC00, 16);
        applyStimulus(32'h0000_0000, 3'd0);
        checkBurst(16);
        pushRepeat(32'h0400_0400, 16);
        applyStimulus(32'hFFFF_FFFF, 3'd0);
        checkBurst(16);
        @(posedge clk);
        #1;
        checkOutput("idleValid", {31'd0, valid}, 32'd0);
        checkOutput("idleError", {31'd0, error}, 32'd1);

        $display("[TB] 16-QAM");
        expQ.push_back(32'h0C00_0400);
        pushRepeat(32'hF400_F400, 7);
        applyStimulus(32'hB000_0000, 3'd1);
        checkBurst(8);
        @(posedge clk);
        #1;
        checkOutput("after16Valid", {31'd0, valid}, 32'd0);
        checkOutput("after16Out", signal_out, 32'd0);

        $display("[TB] 256-QAM and 64-QAM");
        pushRepeat(32'h1400_1400, 4);
        applyStimulus(32'hFFFF_FFFF, 3'd3);
        checkBurst(4);
        pushRepeat(32'h0C00_0C00, 5);
        applyStimulus(32'hFFFF_FFFF, 3'd2);
        checkBurst(5);
        pushRepeat(32'hE400_E400, 4);
        expQ.push_back(32'hE400_F400);
        applyStimulus(32'h0000_000F, 3'd2);
        checkBurst(5);
        expQ.push_back(32'hC400_CC00);
        pushRepeat(32'hC400_C400, 3);
        applyStimulus(32'h0100_0000, 3'd3);
        checkBurst(4);

        $display("[TB] unsupported code");
        applyStimulus(32'h1234_5678, 3'd5);
        checkOutput("badError", {31'd0, error}, 32'd1);
        checkOutput("badValid", {31'd0, valid}, 32'd0);
        checkOutput("badReady", {31'd0, ready}, 32'd1);
        checkOutput("badOut", signal_out, 32'd0);
        pushRepeat(32'h0400_0400, 16);
        applyStimulus(32'hFFFF_FFFF, 3'd0);
        checkOutput("errorCleared", {31'd0, error}, 32'd0);
        checkBurst(16);
        @(posedge clk);
        #1;
        checkOutput("drainedQueue", expQ.size(), 32'd0);

        $display("[TB] reset mid-burst");
        expQ.push_back(32'h0C00_0400);
        pushRepeat(32'hF400_F400, 7);
        applyStimulus(32'hB000_0000, 3'd1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("midRstValid", {31'd0, valid}, 32'd0);
        checkOutput("midRstOut", signal_out, 32'd0);
        checkOutput("midRstError", {31'd0, error}, 32'd0);
        checkOutput("midRstReady", {31'd0, ready}, 32'd0);
        expQ.delete();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("postRstReady", {31'd0, ready}, 32'd1);
        checkOutput("postRstValid", {31'd0, valid}, 32'd0);

        repeat (2) @(posedge clk);
        #1;
        checkOutput("finalQueue", expQ.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/qam_top.md
Name: qam_top

Overview:
- Streaming QAM symbol mapper that sits between a 32-bit data source and the DAC/pulse-shaping path.
- Loads a 32-bit word and splits it MSB-first into k-bit symbols, where k depends on the selected constellation.
- Gray-maps each symbol to signed I/Q amplitudes and emits one symbol per clock, packed as {I,Q}.
- Raises error when an unsupported constellation code is loaded.

Parameters:
- AMP, 1024: amplitude of one constellation unit. Output level = (2*b-(L-1))*AMP. Must satisfy 15*AMP <= 32767.

Ports:
- clk  input  1  system clock; all state changes on rising edge
- rst  input  1  synchronous, active-high reset
- signal_in  input  32  data word; sampled on every rising edge where ready=1
- qam  input  3  constellation select, sampled together with signal_in
- signal_out  output  32  [31:16] = I, [15:0] = Q, both signed two's complement; registered
- ready  output  1  block accepts signal_in/qam on this edge
- valid  output  1  signal_out holds a valid symbol this cycle; registered
- error  output  1  last loaded qam code was unsupported; registered, level

Behaviour:
- qam codes:
  - 0 = 4-QAM: k=2, L=2, N=16 symbols per word.
  - 1 = 16-QAM: k=4, L=4, N=8.
  - 2 = 64-QAM: k=6, L=8, N=5; uses bits [31:2], bits [1:0] are discarded.
  - 3 = 256-QAM: k=8, L=16, N=4.
  - 4-7 = invalid.
- Reset (rst=1 at an edge): signal_out=0, valid=0, error=0, symbol counter=0, state=IDLE.
  - ready=0 while rst is high; ready=1 in the first cycle after rst deasserts.
  - Reset mid-burst discards the remaining symbols.
- States: IDLE and BUSY.
  - ready = !rst & (IDLE | (BUSY & counter==N-1)).
- Load edge (ready=1):
  - Latch signal_in into the shift register.
  - Latch qam; k and N then come from the latched qam.
  - Set counter=0.
- Valid qam at load:
  - error<=0 and state<=BUSY.
  - The first symbol appears on signal_out with valid=1 in the next cycle.
- Invalid qam at load:
  - error<=1, valid<=0, signal_out<=0.
  - State stays IDLE, so ready stays 1 and the next word loads on the next edge.
- BUSY: each cycle emits one symbol, MSB-first.
  - Symbol i = word bits [31-i*k : 32-(i+1)*k].
  - After N symbols, return to IDLE unless a new word loads on the last-symbol edge.
- Back-to-back: ready=1 during the cycle showing symbol N-1. If a word loads on that edge, its symbol 0 follows with no gap (valid continuous).
- When no new symbol is produced, valid<=0 and signal_out<=0.
- Mapping per symbol:
  - Upper k/2 bits are the I Gray code; lower k/2 bits are the Q Gray code.
  - b = gray_to_binary(code).
  - Level = (2*b-(L-1))*AMP, sign-extended to 16 bits.
  - For 4-QAM: bit 1 maps to +AMP, bit 0 maps to -AMP.
- error persists until the next load with a valid qam code.
- Latency: load edge to first valid symbol = 1 cycle. Throughput = 1 symbol/cycle.

Test Plan:
1. Reset 2 cycles, then signal_in=0xFFFFFFFF, qam=0:
   - ready=1 on the first cycle after reset.
   - Then 16 consecutive valid cycles of signal_out=0x04000400.
   - ready high only on the 16th of them.
2. signal_in=0x00000000, qam=0:
   - 16 cycles of 0xFC00FC00 with valid=1.
   - Back-to-back with a following 0xFFFFFFFF word: no valid gap.
3. signal_in=0xB0000000, qam=1:
   - Symbol 0 = 0x0C000400 (I=+3072, Q=+1024).
   - Symbols 1-7 = 0xF400F400.
   - Then valid=0.
4. signal_in=0xFFFFFFFF, qam=3:
   - 4 symbols of 0x14001400 (Gray 1111 gives b=10, level +5).
   - qam=2 with the same word: 5 symbols; the first is 0x0C000C00 (Gray 111 gives b=5, level +3).
5. qam=5 at load:
   - error=1 from the next cycle; valid=0, ready=1.
   - A following load with qam=0 clears error and resumes symbols.
6. Assert rst for one cycle in the middle of a 16-QAM burst:
   - Next cycle: valid=0, signal_out=0, error=0, ready=0.
   - Cycle after: ready=1 and the burst is discarded.
